// File: rtl/fight_action_sequencer_if.sv
// fight_action_sequencer_if: player request inputs and committed action outputs
interface fight_action_sequencer_if;
  logic       btnValid1;
  logic [2:0] btnAction1;
  logic       btnValid2;
  logic [2:0] btnAction2;
  logic [2:0] action1;
  logic [2:0] action2;
  logic       actionEnable;
  modport master (output btnValid1, btnAction1, btnValid2, btnAction2,
                  input action1, action2, actionEnable);
  modport slave (input btnValid1, btnAction1, btnValid2, btnAction2,
                 output action1, action2, actionEnable);
endinterface

// File: rtl/fight_action_sequencer.sv
// fight_action_sequencer: queues per-player actions and issues paired rounds with a one-cycle strobe
module fight_action_sequencer #(
  parameter int         DEPTH          = 2,
  parameter int         TIMEOUT_CYCLES = 16,
  parameter int         COOLDOWN       = 3,
  parameter logic [2:0] IDLE_ACTION    = 3'b000
) (
  input  logic                            clk,
  input  logic                            resetGame,
  input  logic                            gameOver,
  fight_action_sequencer_if.slave         bus,
  output logic [7:0]                      roundCount,
  output logic                            drop1,
  output logic                            drop2,
  output logic                            busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW = $clog2(COOLDOWN + 1);
  typedef enum logic [2:0] {WAIT, LOAD, FIRE, COOL, HALT} state_t;
  state_t        state, state_n;
  logic [TW-1:0] tmo, tmo_n;
  logic [CW-1:0] cool, cool_n;
  logic [2:0]    mem [2][DEPTH];
  logic [AW-1:0] wp [2];
  logic [AW-1:0] rp [2];
  logic [AW:0]   cnt [2];
  logic [2:0]    code [2];
  logic [1:0]    vld, nemp, full, pop, push_req, push;
  assign vld     = {bus.btnValid2, bus.btnValid1};
  assign code[0] = bus.btnAction1;
  assign code[1] = bus.btnAction2;
  // FIFO status; a pop in the same cycle frees a slot for a push into a full FIFO
  always_comb begin
    nemp = '0;
    full = '0;
    pop = '0;
    push_req = '0;
    push = '0;
    for (int p = 0; p < 2; p++) begin
      nemp[p]     = cnt[p] != '0;
      full[p]     = cnt[p] == (AW+1)'(DEPTH);
      pop[p]      = state == LOAD && nemp[p];
      push_req[p] = vld[p] && code[p] != 3'b000 && state != HALT;
      push[p]     = push_req[p] && (!full[p] || pop[p]);
    end
  end
  // next-state logic with wait-timeout and cooldown counters
  always_comb begin
    state_n = state;
    tmo_n = '0;
    cool_n = '0;
    case (state)
      WAIT: begin
        if (gameOver) state_n = HALT;
        else if (&nemp) state_n = LOAD;
        else if (|nemp) begin
          if (tmo == TW'(TIMEOUT_CYCLES - 1)) state_n = LOAD;
          else tmo_n = tmo + 1'b1;
        end
      end
      LOAD: state_n = FIRE;
      FIRE: state_n = COOL;
      COOL: begin
        if (cool == CW'(COOLDOWN - 1)) state_n = gameOver ? HALT : WAIT;
        else cool_n = cool + 1'b1;
      end
      HALT: state_n = gameOver ? HALT : WAIT;
      default: state_n = WAIT;
    endcase
  end
  // state and counter registers
  always_ff @(posedge clk or negedge resetGame) begin
    if (!resetGame) begin
      state <= WAIT;
      tmo <= '0;
      cool <= '0;
    end else begin
      state <= state_n;
      tmo <= tmo_n;
      cool <= cool_n;
    end
  end
  // FIFO pointers and occupancy; HALT flushes both queues
  always_ff @(posedge clk or negedge resetGame) begin
    if (!resetGame) begin
      for (int p = 0; p < 2; p++) begin
        wp[p] <= '0;
        rp[p] <= '0;
        cnt[p] <= '0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (state == HALT) begin
          wp[p] <= '0;
          rp[p] <= '0;
          cnt[p] <= '0;
        end else begin
          if (push[p]) wp[p] <= wp[p] + 1'b1;
          if (pop[p]) rp[p] <= rp[p] + 1'b1;
          cnt[p] <= cnt[p] + (AW+1)'(push[p]) - (AW+1)'(pop[p]);
        end
      end
    end
  end
  // FIFO storage
  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++)
      if (push[p]) mem[p][wp[p]] <= code[p];
  end
  // registered outputs: commit in LOAD, strobe in FIRE, sticky drop flags
  always_ff @(posedge clk or negedge resetGame) begin
    if (!resetGame) begin
      bus.action1 <= IDLE_ACTION;
      bus.action2 <= IDLE_ACTION;
      bus.actionEnable <= 1'b0;
      roundCount <= '0;
      drop1 <= 1'b0;
      drop2 <= 1'b0;
      busy <= 1'b0;
    end else begin
      if (state == LOAD) begin
        bus.action1 <= pop[0] ? mem[0][rp[0]] : IDLE_ACTION;
        bus.action2 <= pop[1] ? mem[1][rp[1]] : IDLE_ACTION;
      end
      bus.actionEnable <= state == LOAD;
      if (state == FIRE && roundCount != 8'd255) roundCount <= roundCount + 8'd1;
      drop1 <= drop1 | (push_req[0] & ~push[0]);
      drop2 <= drop2 | (push_req[1] & ~push[1]);
      busy <= state_n inside {LOAD, FIRE, COOL};
    end
  end
endmodule

// File: tb/tb_fight_action_sequencer.sv
// tb_fight_action_sequencer: scoreboard bench for the round sequencer
module tb_fight_action_sequencer;
  logic       clk = 1'b0;
  logic       resetGame = 1'b0;
  logic       gameOver = 1'b0;
  logic [7:0] roundCount;
  logic       drop1, drop2, busy;
  int         checks = 0;
  int         failures = 0;
  int         strobes = 0;
  int         rc_exp = 0;
  logic       prev_en = 1'b0;
  logic [5:0] sb [$];

  fight_action_sequencer_if bus ();

  fight_action_sequencer dut (
    .clk(clk), .resetGame(resetGame), .gameOver(gameOver), .bus(bus),
    .roundCount(roundCount), .drop1(drop1), .drop2(drop2), .busy(busy)
  );

  always #5 clk = ~clk;

  // every strobe must be single-cycle and match the oldest expected pair
  always @(negedge clk) begin
    logic       have;
    logic [5:0] exp;
    if (bus.actionEnable) begin
      strobes++;
      have = sb.size() != 0;
      exp = have ? sb.pop_front() : 6'd0;
      checks++;
      if (prev_en || !have || {bus.action1, bus.action2} !== exp) begin
        failures++;
        $display("FAIL strobe got=%b_%b exp=%b_%b expected_pending=%0d prev_en=%0d",
                 bus.action1, bus.action2, exp[5:3], exp[2:0], have, prev_en);
      end
    end
    prev_en = bus.actionEnable;
  end

  task automatic drive(input logic v1, input logic [2:0] a1, input logic v2, input logic [2:0] a2);
    bus.btnValid1 = v1;
    bus.btnAction1 = a1;
    bus.btnValid2 = v2;
    bus.btnAction2 = a2;
    @(negedge clk);
    bus.btnValid1 = 1'b0;
    bus.btnValid2 = 1'b0;
  endtask

  task automatic wait_strobe(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      if (bus.actionEnable) begin
        n = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    bus.btnValid1 = 1'b0;
    bus.btnValid2 = 1'b0;
    bus.btnAction1 = 3'b000;
    bus.btnAction2 = 3'b000;
    resetGame = 1'b0;
    repeat (3) @(negedge clk);
    resetGame = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.action1, bus.action2, bus.actionEnable, roundCount, drop1, drop2, busy} !== 18'd0) begin
      failures++;
      $display("FAIL reset_state got a1=%b a2=%b en=%b rc=%0d d1=%b d2=%b busy=%b exp all zero",
               bus.action1, bus.action2, bus.actionEnable, roundCount, drop1, drop2, busy);
    end
  endtask

  task automatic test_pair;
    int n;
    drive(1'b1, 3'b010, 1'b1, 3'b101);
    sb.push_back({3'b010, 3'b101});
    rc_exp++;
    wait_strobe(n);
    checks++;
    if (n !== 3) begin
      failures++;
      $display("FAIL pair_latency got=%0d exp=3", n);
    end
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL pair_busy got=%b exp=1", busy);
    end
    @(negedge clk);
    checks++;
    if (bus.actionEnable !== 1'b0 || roundCount !== 8'(rc_exp)) begin
      failures++;
      $display("FAIL pair_after en=%b rc=%0d exp en=0 rc=%0d", bus.actionEnable, roundCount, rc_exp);
    end
    checks++;
    if (bus.action1 !== 3'b010 || bus.action2 !== 3'b101) begin
      failures++;
      $display("FAIL pair_hold got=%b_%b exp=010_101", bus.action1, bus.action2);
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_timeout;
    int n, s0;
    drive(1'b1, 3'b011, 1'b0, 3'b000);
    sb.push_back({3'b011, 3'b000});
    rc_exp++;
    s0 = strobes;
    wait_strobe(n);
    checks++;
    if (n !== 18) begin
      failures++;
      $display("FAIL timeout_latency got=%0d exp=18", n);
    end
    repeat (40) @(negedge clk);
    checks++;
    if (strobes - s0 !== 1) begin
      failures++;
      $display("FAIL timeout_strobes got=%0d exp=1", strobes - s0);
    end
  endtask

  task automatic test_drop;
    int n;
    drive(1'b1, 3'b001, 1'b0, 3'b000);
    drive(1'b1, 3'b010, 1'b0, 3'b000);
    drive(1'b1, 3'b011, 1'b0, 3'b000);
    sb.push_back({3'b001, 3'b000});
    sb.push_back({3'b010, 3'b000});
    rc_exp += 2;
    checks++;
    if (drop1 !== 1'b1 || drop2 !== 1'b0) begin
      failures++;
      $display("FAIL drop_flags got d1=%b d2=%b exp d1=1 d2=0", drop1, drop2);
    end
    for (int r = 0; r < 2; r++) begin
      wait_strobe(n);
      checks++;
      if (n < 0) begin
        failures++;
        $display("FAIL drop_round%0d got=timeout exp=strobe", r);
      end
      @(negedge clk);
    end
    repeat (40) @(negedge clk);
    checks++;
    if (sb.size() !== 0 || roundCount !== 8'(rc_exp)) begin
      failures++;
      $display("FAIL drop_drain pending=%0d rc=%0d exp pending=0 rc=%0d", sb.size(), roundCount, rc_exp);
    end
  endtask

  task automatic test_gameover;
    int n, s0;
    drive(1'b1, 3'b100, 1'b1, 3'b110);
    sb.push_back({3'b100, 3'b110});
    rc_exp++;
    wait_strobe(n);
    gameOver = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || roundCount !== 8'(rc_exp) || sb.size() !== 0) begin
      failures++;
      $display("FAIL gameover_round busy=%b rc=%0d pending=%0d exp busy=0 rc=%0d pending=0",
               busy, roundCount, sb.size(), rc_exp);
    end
    s0 = strobes;
    drive(1'b1, 3'b110, 1'b1, 3'b111);
    drive(1'b1, 3'b101, 1'b1, 3'b001);
    drive(1'b1, 3'b111, 1'b1, 3'b010);
    repeat (5) @(negedge clk);
    gameOver = 1'b0;
    repeat (30) @(negedge clk);
    checks++;
    if (strobes !== s0 || drop1 !== 1'b1 || drop2 !== 1'b0) begin
      failures++;
      $display("FAIL halt_ignore strobes=%0d d1=%b d2=%b exp strobes=%0d d1=1 d2=0", strobes, drop1, drop2, s0);
    end
    drive(1'b1, 3'b111, 1'b1, 3'b011);
    sb.push_back({3'b111, 3'b011});
    rc_exp++;
    wait_strobe(n);
    checks++;
    if (n !== 3) begin
      failures++;
      $display("FAIL resume_latency got=%0d exp=3", n);
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_async_reset;
    int n, s0;
    drive(1'b1, 3'b101, 1'b1, 3'b010);
    sb.push_back({3'b101, 3'b010});
    wait_strobe(n);
    drive(1'b1, 3'b001, 1'b1, 3'b011);
    drive(1'b1, 3'b110, 1'b1, 3'b100);
    #2 resetGame = 1'b0;
    #1;
    checks++;
    if ({bus.action1, bus.action2, bus.actionEnable, roundCount, drop1, drop2, busy} !== 18'd0) begin
      failures++;
      $display("FAIL async_reset a1=%b a2=%b en=%b rc=%0d d1=%b d2=%b busy=%b exp all zero",
               bus.action1, bus.action2, bus.actionEnable, roundCount, drop1, drop2, busy);
    end
    sb.delete();
    rc_exp = 0;
    @(negedge clk);
    resetGame = 1'b1;
    s0 = strobes;
    repeat (30) @(negedge clk);
    checks++;
    if (strobes !== s0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_flush strobes=%0d busy=%b exp strobes=%0d busy=0", strobes, busy, s0);
    end
  endtask

  task automatic test_saturate;
    int n, s0;
    logic [2:0] a, b;
    s0 = strobes;
    for (int i = 0; i < 256; i++) begin
      a = 3'($urandom_range(1, 7));
      b = 3'($urandom_range(1, 7));
      drive(1'b1, a, 1'b1, b);
      sb.push_back({a, b});
      rc_exp = rc_exp == 255 ? 255 : rc_exp + 1;
      wait_strobe(n);
      @(negedge clk);
      checks++;
      if (n < 0 || roundCount !== 8'(rc_exp)) begin
        failures++;
        $display("FAIL saturate_round%0d wait=%0d rc=%0d exp rc=%0d", i, n, roundCount, rc_exp);
      end
    end
    repeat (10) @(negedge clk);
    checks++;
    if (strobes - s0 !== 256 || roundCount !== 8'd255 || sb.size() !== 0) begin
      failures++;
      $display("FAIL saturate_total strobes=%0d rc=%0d pending=%0d exp strobes=256 rc=255 pending=0",
               strobes - s0, roundCount, sb.size());
    end
  endtask

  initial begin
    test_reset;
    test_pair;
    test_timeout;
    test_drop;
    test_gameover;
    test_async_reset;
    test_saturate;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
